tasha_replay_shifter: RTL and testbench
=======================================

// Module: tasha_replay_shifter
// PURPOSE
// - Parametrised controller-replay engine: N console ports, L data lines/port, S-bit serial frames.
// - Buffers replay words from the memory/UART side in a small FIFO.
// - Pops one word per console latch and shifts it out on per-port console clocks.
// - Replaces fixed 2-port/2-line latch/clock logic; sits between replay memory path and GPIO pins.
// PARAMETERS
// - NUM_PORTS      2   console controller ports
// - LINES_PER_PORT 2   data lines per port
// - SHIFT_BITS     16  bits per frame per line
// - FIFO_DEPTH     8   replay words buffered; power of 2, >=2
// - SYNC_STAGES    2   synchroniser flops on i_latch / i_pclk
// - FILTER_CYCLES  3   latch qualification length (only with TASHA_LATCH_FILTER_EN)
// - Derived: NL = NUM_PORTS*LINES_PER_PORT; WORD_W = NL*SHIFT_BITS (64 by default)
// PORTS
// - i_sys_clk_12       in   1          sole clock
// - i_reset            in   1          asynchronous, active-high reset
// - i_latch            in   1          console latch, asynchronous
// - i_pclk             in   NUM_PORTS  console clock per port, asynchronous
// - i_word_valid       in   1          replay word offered
// - i_word_data        in   WORD_W     field k=p*L+l at [k*S +: S], MSB shifted first
// - o_word_ready       out  1          FIFO accepts (= !full, forced 0 while i_reset)
// - o_pd               out  NL         serial data, index p*L+l
// - o_latched          out  1          registered echo of synchronised latch
// - o_pclked           out  NUM_PORTS  registered echo of synchronised port clocks
// - o_underflow        out  1          sticky: latch seen with FIFO empty
// - i_clear_underflow  in   1          clears o_underflow
// - o_fifo_level       out  $clog2(FIFO_DEPTH)+1  words held
// - o_latch_count      out  16         recognised latches, wraps FFFF->0000
// BEHAVIOUR
// - Reset values: o_pd all 1; o_latched 0; o_pclked 0; o_underflow 0; level 0; count 0; FIFO empty.
// - Sync: i_latch/i_pclk pass SYNC_STAGES flops; edges detected on synchronised values.
// - Push: transfer when i_word_valid & o_word_ready. No write bypass: a word pushed in the same
//   cycle as a pop request on an empty FIFO is not returned by that pop.
// - Latch rising edge (recognised):
//   - FIFO non-empty: pop; load field k into shreg[k].
//   - FIFO empty: load all 1 (idle, no buttons); set o_underflow.
//   - Either case: o_latch_count += 1.
//   - Effect: o_pd reflects the new word 1 cycle after recognition;
//     pin-to-pin latency SYNC_STAGES+2 cycles.
// - While synchronised latch is high: port clocks ignored; no further loads.
// - Port clock rising edge, latch low: every shreg of port p shifts left 1, LSB filled with 1.
//   - After S shifts the line reads 1 indefinitely.
// - o_pd[k] = shreg[k][S-1].
// - Latch edge and pclk edge in the same cycle: load wins, no shift that cycle.
// - Underflow set and i_clear_underflow in the same cycle: set wins.
// - Pop and push same cycle (non-empty, non-full): both occur; level unchanged.
// - Reset mid-frame: all state to reset values immediately; buffered words discarded.
// CONFIGURATION
// - TASHA_LATCH_FILTER_EN defined:
//   - Latch recognised only after synchronised latch high for FILTER_CYCLES consecutive cycles.
//   - Recognition occurs on that cycle; shorter pulses ignored, no pop, no count.
//   - Adds FILTER_CYCLES-1 cycles latency.
// - Not defined: recognised on the first cycle the synchronised latch is seen high;
//   FILTER_CYCLES unused.
// STRUCTURE
// - tasha_replay_pkg:
//   - word_w(NUM_PORTS, LINES_PER_PORT, SHIFT_BITS) function
//   - field index helper
//   - IDLE_BIT = 1'b1
//   - LATCH_COUNT_W = 16
// - Sub-module replay_word_fifo:
//   - synchronous FIFO, width WORD_W, depth FIFO_DEPTH
//   - ports: push/pop, full/empty, level
//   - same clock and reset as parent
// - Top holds synchronisers, edge detect, optional filter, shift registers, counters.
// TESTING
// - Push 64'h0123_4567_89AB_CDEF, pulse latch, 17 port-0 clocks -> o_pd[0] = 0xCDEF MSB-first
//   then 1; o_pd[1] = 0x89AB; o_pd[2..3] stay at field MSBs (port 1 unclocked).
// - Latch on empty FIFO -> o_pd=4'b1111, o_underflow=1, count=1;
//   pulse i_clear_underflow -> o_underflow=0.
// - Push 8 words -> level=8, o_word_ready=0, 9th offer not taken;
//   latch -> level=7, ready=1 next cycle.
// - Latch and port-0 clock edges in same cycle -> word loaded, first bit not skipped.
// - Assert i_reset after 5 shifts with 3 words buffered -> o_pd all 1, level=0, count=0,
//   ready=0 during reset.
// - Filter build: 2-cycle latch pulse ignored (count unchanged), 4-cycle pulse recognised;
//   no-filter build: both recognised.

Source files
------------

// File: rtl/tasha_replay_pkg.sv
// Shared constants and helpers for the tasha replay shifter block.
package tasha_replay_pkg;

    localparam logic IDLE_BIT      = 1'b1;
    localparam int   LATCH_COUNT_W = 16;

    function automatic int word_w(input int num_ports, input int lines_per_port, input int shift_bits);
        return num_ports * lines_per_port * shift_bits;
    endfunction

    function automatic int field_index(input int port, input int line, input int lines_per_port);
        return port * lines_per_port + line;
    endfunction

endpackage

// File: rtl/tasha_replay_shifter_if.sv
// Replay-word handshake between the memory/UART source and the shifter FIFO.
interface tasha_replay_shifter_if
    import tasha_replay_pkg::*;
#(
    parameter int WORD_W = word_w(2, 2, 16)
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (output word_valid, output word_data, input word_ready);
    modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/tasha_replay_shifter_fifo.sv
// Synchronous replay-word FIFO; read data is the head word, no write-to-read bypass.
module replay_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign level     = wr_ptr_r - rd_ptr_r;
    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == {(AW+1){1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/tasha_replay_shifter.sv
// Controller-replay engine: FIFO of replay words shifted out on console latch/clock pins.
// Optional latch qualification filter: define TASHA_LATCH_FILTER_EN.
module tasha_replay_shifter
    import tasha_replay_pkg::*;
#(
    parameter  int NUM_PORTS      = 2,
    parameter  int LINES_PER_PORT = 2,
    parameter  int SHIFT_BITS     = 16,
    parameter  int FIFO_DEPTH     = 8,
    parameter  int SYNC_STAGES    = 2,
    parameter  int FILTER_CYCLES  = 3,
    localparam int NL             = NUM_PORTS * LINES_PER_PORT,
    localparam int WORD_W         = word_w(NUM_PORTS, LINES_PER_PORT, SHIFT_BITS),
    localparam int LEVEL_W        = $clog2(FIFO_DEPTH) + 1
)(
    input  logic                     i_sys_clk_12,
    input  logic                     i_reset,
    input  logic                     i_latch,
    input  logic [NUM_PORTS-1:0]     i_pclk,
    tasha_replay_shifter_if.slave    word_if,
    output logic [NL-1:0]            o_pd,
    output logic                     o_latched,
    output logic [NUM_PORTS-1:0]     o_pclked,
    output logic                     o_underflow,
    input  logic                     i_clear_underflow,
    output logic [LEVEL_W-1:0]       o_fifo_level,
    output logic [LATCH_COUNT_W-1:0] o_latch_count
);
`ifdef TASHA_LATCH_FILTER_EN
    localparam int QUAL_CYCLES = FILTER_CYCLES;
`else
    localparam int QUAL_CYCLES = 1;
`endif
    localparam int QCNT_W = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0]   latch_sync_r;
    logic [SYNC_STAGES-1:0]   pclk_sync_r [NUM_PORTS];
    logic                     latched_r;
    logic [NUM_PORTS-1:0]     pclked_r;
    logic [NUM_PORTS-1:0]     pclked_prev_r;
    logic [QCNT_W-1:0]        qual_cnt_r;
    logic                     underflow_r;
    logic [LATCH_COUNT_W-1:0] latch_count_r;
    logic [SHIFT_BITS-1:0]    shreg_r [NL];

    logic                     recognise_s;
    logic [NUM_PORTS-1:0]     pclk_rise_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [WORD_W-1:0]        fifo_rdata_s;
    logic                     push_s;
    logic                     pop_s;

    assign word_if.word_ready = ~fifo_full_s & ~i_reset;
    assign push_s             = word_if.word_valid & word_if.word_ready;
    assign pop_s              = recognise_s & ~fifo_empty_s;
    assign recognise_s        = latched_r & (qual_cnt_r == QCNT_W'(QUAL_CYCLES - 1));
    assign pclk_rise_s        = pclked_r & ~pclked_prev_r;
    assign o_latched          = latched_r;
    assign o_pclked           = pclked_r;
    assign o_underflow        = underflow_r;
    assign o_latch_count      = latch_count_r;

    replay_word_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_sys_clk_12),
        .rst   (i_reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (word_if.word_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (o_fifo_level)
    );

    // Pin synchronisers plus one echo stage on which edges are detected.
    always_ff @(posedge i_sys_clk_12 or posedge i_reset) begin
        if (i_reset) begin
            latch_sync_r  <= {SYNC_STAGES{1'b0}};
            latched_r     <= 1'b0;
            pclked_r      <= {NUM_PORTS{1'b0}};
            pclked_prev_r <= {NUM_PORTS{1'b0}};
            for (int p = 0; p < NUM_PORTS; p++) pclk_sync_r[p] <= {SYNC_STAGES{1'b0}};
        end else begin
            latch_sync_r  <= (latch_sync_r << 1) | SYNC_STAGES'(i_latch);
            latched_r     <= latch_sync_r[SYNC_STAGES-1];
            pclked_prev_r <= pclked_r;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pclk_sync_r[p] <= (pclk_sync_r[p] << 1) | SYNC_STAGES'(i_pclk[p]);
                pclked_r[p]    <= pclk_sync_r[p][SYNC_STAGES-1];
            end
        end
    end

    // Consecutive-high counter; saturates so a held latch is recognised only once.
    always_ff @(posedge i_sys_clk_12 or posedge i_reset) begin
        if (i_reset) begin
            qual_cnt_r <= {QCNT_W{1'b0}};
        end else if (!latched_r) begin
            qual_cnt_r <= {QCNT_W{1'b0}};
        end else if (qual_cnt_r != QCNT_W'(QUAL_CYCLES)) begin
            qual_cnt_r <= qual_cnt_r + QCNT_W'(1);
        end
    end

    // Latch statistics: recognised-latch counter and sticky underflow flag.
    always_ff @(posedge i_sys_clk_12 or posedge i_reset) begin
        if (i_reset) begin
            underflow_r   <= 1'b0;
            latch_count_r <= {LATCH_COUNT_W{1'b0}};
        end else begin
            if (recognise_s) latch_count_r <= latch_count_r + LATCH_COUNT_W'(1);
            if (recognise_s && fifo_empty_s) underflow_r <= 1'b1;
            else if (i_clear_underflow)      underflow_r <= 1'b0;
        end
    end

    // One shift register per data line; a load on latch pre-empts any port clock.
    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        for (genvar gl = 0; gl < LINES_PER_PORT; gl++) begin : g_line
            localparam int K = field_index(gp, gl, LINES_PER_PORT);

            // Load from the popped word (or idle on empty) or shift toward the pin.
            always_ff @(posedge i_sys_clk_12 or posedge i_reset) begin
                if (i_reset) begin
                    shreg_r[K] <= {SHIFT_BITS{IDLE_BIT}};
                end else if (recognise_s) begin
                    shreg_r[K] <= fifo_empty_s ? {SHIFT_BITS{IDLE_BIT}}
                                               : fifo_rdata_s[K*SHIFT_BITS +: SHIFT_BITS];
                end else if (pclk_rise_s[gp] && !latched_r) begin
                    shreg_r[K] <= {shreg_r[K][SHIFT_BITS-2:0], IDLE_BIT};
                end
            end

            assign o_pd[K] = shreg_r[K][SHIFT_BITS-1];
        end
    end
endmodule

// File: tb/tb_tasha_replay_shifter.sv
// Self-checking bench for tasha_replay_shifter: pin-level behavioural model plus directed literals.
module tb_tasha_replay_shifter;
    localparam int NP = 2, LP = 2, SB = 16, DEPTH = 8, SS = 2, FC = 3;
    localparam int NL = NP * LP, WW = NL * SB;
`ifdef TASHA_LATCH_FILTER_EN
    localparam int Q = FC;
`else
    localparam int Q = 1;
`endif

    logic          clk = 1'b0, rst = 1'b1, latch = 1'b0, clr = 1'b0;
    logic [NP-1:0] pclk = '0;
    logic [NL-1:0] pd;
    logic          latched, underflow;
    logic [NP-1:0] pclked;
    logic [3:0]    level;
    logic [15:0]   count;

    tasha_replay_shifter_if #(.WORD_W(WW)) word_if ();

    tasha_replay_shifter #(
        .NUM_PORTS(NP), .LINES_PER_PORT(LP), .SHIFT_BITS(SB),
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC)
    ) dut (
        .i_sys_clk_12(clk), .i_reset(rst), .i_latch(latch), .i_pclk(pclk),
        .word_if(word_if), .o_pd(pd), .o_latched(latched), .o_pclked(pclked),
        .o_underflow(underflow), .i_clear_underflow(clr),
        .o_fifo_level(level), .o_latch_count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WW-1:0] mq[$];
    logic [SB-1:0] m_val [NL];
    int            m_sh  [NL];
    logic          m_unf;
    logic [15:0]   m_cnt;
    int            m_run;
    logic          lh [0:SS+1];
    logic [NP-1:0] ph [0:SS+1];

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < NL; k++) begin m_val[k] = 16'hFFFF; m_sh[k] = 0; end
        m_unf = 1'b0; m_cnt = 16'd0; m_run = 0;
        for (int j = 0; j <= SS + 1; j++) begin lh[j] = 1'b0; ph[j] = '0; end
    endtask

    function automatic logic [NL-1:0] exp_pd();
        logic [NL-1:0] r;
        for (int k = 0; k < NL; k++) r[k] = (m_sh[k] >= SB) ? 1'b1 : m_val[k][SB-1-m_sh[k]];
        return r;
    endfunction

    task automatic model_step(input logic s_rst, input logic s_latch, input logic [NP-1:0] s_pclk,
                              input logic s_valid, input logic [WW-1:0] s_data, input logic s_clr);
        logic cur, rec, rdy, unf_set;
        logic [NP-1:0] rise;
        logic [WW-1:0] w;
        if (s_rst) begin
            model_reset();
        end else begin
            cur = lh[SS]; rec = 1'b0; unf_set = 1'b0;
            if (cur) begin
                if (m_run < Q) begin m_run++; rec = (m_run == Q); end
            end else m_run = 0;
            rise = ph[SS] & ~ph[SS+1];
            rdy  = (mq.size() < DEPTH);
            if (rec) begin
                m_cnt++;
                if (mq.size() > 0) begin
                    w = mq.pop_front();
                    for (int k = 0; k < NL; k++) begin m_val[k] = w[k*SB +: SB]; m_sh[k] = 0; end
                end else begin
                    for (int k = 0; k < NL; k++) begin m_val[k] = 16'hFFFF; m_sh[k] = 0; end
                    unf_set = 1'b1;
                end
            end else if (!cur) begin
                for (int k = 0; k < NL; k++)
                    if (rise[k / LP] && m_sh[k] < SB) m_sh[k]++;
            end
            if (unf_set) m_unf = 1'b1;
            else if (s_clr) m_unf = 1'b0;
            if (s_valid && rdy) mq.push_back(s_data);
            for (int j = SS + 1; j > 0; j--) begin lh[j] = lh[j-1]; ph[j] = ph[j-1]; end
            lh[0] = s_latch; ph[0] = s_pclk;
        end
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        logic          s_rst, s_latch, s_valid, s_clr;
        logic [NP-1:0] s_pclk;
        logic [WW-1:0] s_data;
        model_reset();
        forever begin
            @(posedge clk);
            s_rst = rst; s_latch = latch; s_pclk = pclk; s_clr = clr;
            s_valid = word_if.word_valid; s_data = word_if.word_data;
            #1;
            model_step(s_rst, s_latch, s_pclk, s_valid, s_data, s_clr);
            check("pd",        64'(pd),        64'(exp_pd()));
            check("latched",   64'(latched),   64'(lh[SS]));
            check("pclked",    64'(pclked),    64'(ph[SS]));
            check("underflow", 64'(underflow), 64'(m_unf));
            check("level",     64'(level),     64'(mq.size()));
            check("count",     64'(count),     64'(m_cnt));
            check("ready",     64'(word_if.word_ready), 64'(!rst && mq.size() < DEPTH));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [WW-1:0] w);
        word_if.word_valid = 1'b1; word_if.word_data = w;
        tick(1);
        word_if.word_valid = 1'b0;
    endtask

    task automatic pulse_latch(input int hi);
        latch = 1'b1; tick(hi); latch = 1'b0; tick(SS + 4 + Q);
    endtask

    task automatic pulse_pclk0();
        pclk[0] = 1'b1; tick(2); pclk[0] = 1'b0; tick(3);
    endtask

    initial begin
        logic [15:0] ser0, ser1;
        logic [WW-1:0] b [DEPTH];
        int c0, lv0;
        word_if.word_valid = 1'b0; word_if.word_data = '0;
        tick(3);
        check("rst_pd", 64'(pd), 64'hF);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(word_if.word_ready), 64'd0);
        rst = 1'b0; tick(2);
        check("idle_ready", 64'(word_if.word_ready), 64'd1);
        check("idle_count", 64'(count), 64'd0);

        // Basic frame, port 0 clocked only
        push_word(64'h0123_4567_89AB_CDEF);
        tick(1);
        pulse_latch(4);
        check("load_pd", 64'(pd), 64'h3);
        check("load_count", 64'(count), 64'd1);
        ser0[15] = pd[0]; ser1[15] = pd[1];
        for (int i = 1; i < 16; i++) begin
            pulse_pclk0();
            ser0[15-i] = pd[0]; ser1[15-i] = pd[1];
        end
        check("serial_l0", 64'(ser0), 64'hCDEF);
        check("serial_l1", 64'(ser1), 64'h89AB);
        pulse_pclk0(); pulse_pclk0();
        check("after17_p0", 64'(pd[1:0]), 64'h3);
        check("after17_p1", 64'(pd[3:2]), 64'h0);

        // Latch on empty FIFO
        pulse_latch(4);
        check("empty_pd", 64'(pd), 64'hF);
        check("empty_unf", 64'(underflow), 64'd1);
        check("empty_count", 64'(count), 64'd2);
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        check("unf_cleared", 64'(underflow), 64'd0);

        // Reset mid-frame with three words buffered
        for (int i = 0; i < 4; i++) push_word({16'hF000 + 16'(i), 16'h0F0F, 16'h5A5A, 16'hC3C3 ^ 16'(i)});
        tick(1);
        pulse_latch(4);
        for (int i = 0; i < 5; i++) pulse_pclk0();
        check("pre_rst_level", 64'(level), 64'd3);
        check("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b1; #1;
        check("mid_rst_pd", 64'(pd), 64'hF);
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_ready", 64'(word_if.word_ready), 64'd0);
        tick(3); rst = 1'b0; tick(2);

        // Fill FIFO to capacity
        for (int i = 0; i < DEPTH; i++)
            b[i] = {16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 16'hA5A4 + 16'(i)};
        for (int i = 0; i < DEPTH; i++) begin
            word_if.word_valid = 1'b1; word_if.word_data = b[i]; tick(1);
        end
        word_if.word_valid = 1'b0; tick(1);
        check("full_level", 64'(level), 64'd8);
        check("full_ready", 64'(word_if.word_ready), 64'd0);
        word_if.word_valid = 1'b1; word_if.word_data = 64'hDEAD_BEEF_DEAD_BEEF; tick(3);
        word_if.word_valid = 1'b0; tick(1);
        check("ninth_level", 64'(level), 64'd8);
        pulse_latch(4);
        check("pop_level", 64'(level), 64'd7);
        check("pop_ready", 64'(word_if.word_ready), 64'd1);

        // Latch and port-0 clock rising together: second word (field0 A5A5)
        latch = 1'b1; pclk[0] = 1'b1; tick(4);
        latch = 1'b0; pclk[0] = 1'b0; tick(SS + 4 + Q);
        check("same_edge_bit15", 64'(pd[0]), 64'd1);
        pulse_pclk0();
        check("same_edge_bit14", 64'(pd[0]), 64'd0);

        // Push landing on the pop edge keeps the level
        lv0 = int'(level);
        latch = 1'b1; tick(SS + Q);
        word_if.word_valid = 1'b1; word_if.word_data = 64'h7777_6666_5555_4444; tick(1);
        word_if.word_valid = 1'b0; tick(3);
        latch = 1'b0; tick(SS + 4);
        check("push_pop_level", 64'(level), 64'(lv0));

        // Short and long latch pulses
        c0 = int'(count);
        pulse_latch(2);
        check("short_latch", 64'(count), 64'(c0 + ((2 >= Q) ? 1 : 0)));
        pulse_latch(4);
        check("long_latch", 64'(count), 64'(c0 + ((2 >= Q) ? 1 : 0) + 1));

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
